// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences every data_path control line
// for R-type, lw, sw, beq and addi, with optional memory wait states.
module multicycle_control_unit #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] Funct,
  input  logic       zero,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       PC_enable,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       PCSrc,
  output logic       illegal_op,
  output logic [3:0] state_disp
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTE  = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] ADDIEXEC = 4'd9;
  localparam logic [3:0] ADDIWB   = 4'd10;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  logic [3:0] state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       mem_done;
  logic       is_r, is_lw, is_sw, is_beq, is_addi;
  logic       fn_ok;
  logic [2:0] fn_alu;
  logic       illegal;
  logic       pc_write, ir_write, mem_write, reg_write;

  assign is_r    = (op == 6'h00);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_addi = (op == 6'h08);
  assign mem_done = (wait_cnt_q == WAIT_LAST);

  always_comb begin
    fn_ok  = 1'b1;
    fn_alu = 3'b000;
    unique case (1'b1)
      (Funct == 6'h20): fn_alu = 3'b000;
      (Funct == 6'h22): fn_alu = 3'b001;
      (Funct == 6'h24): fn_alu = 3'b010;
      (Funct == 6'h25): fn_alu = 3'b011;
      (Funct == 6'h2A): fn_alu = 3'b100;
      default:          fn_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      FETCH:   if (mem_done) state_d = DECODE;
      DECODE: begin
        unique case (1'b1)
          (is_lw || is_sw):  state_d = MEMADR;
          (is_r && fn_ok):   state_d = EXECUTE;
          is_beq:            state_d = BRANCH;
          is_addi:           state_d = ADDIEXEC;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR:   state_d = is_sw ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_done) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      EXECUTE:  state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      ADDIEXEC: state_d = ADDIWB;
      ADDIWB:   state_d = FETCH;
      default:  state_d = FETCH;
    endcase
    // counter only advances while parked in a memory-wait state
    if (state_d != state_q) wait_cnt_d = 4'd0;
    else if (state_q == FETCH || state_q == MEMREAD)
      wait_cnt_d = wait_cnt_q + 4'd1;
    else wait_cnt_d = 4'd0;
  end

  always_comb begin
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    PCSrc      = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    case (state_q)
      FETCH: begin
        IorD     = 1'b1;
        ALUSrcB  = 2'b01;
        pc_write = mem_done;
        ir_write = mem_done;
      end
      DECODE:   ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMWB: begin
        reg_write = 1'b1;
        MemtoReg  = 1'b1;
      end
      MEMWRITE: mem_write = 1'b1;
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = fn_alu;
      end
      ALUWB: begin
        reg_write = 1'b1;
        RegDst    = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b001;
        PCSrc      = 1'b1;
        pc_write   = zero;
      end
      ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB:   reg_write = 1'b1;
      default: ;
    endcase
  end

  // enables are held off for the whole reset window
  assign PC_enable  = pc_write & reset;
  assign IRWrite    = ir_write & reset;
  assign MemWrite   = mem_write & reset;
  assign RegWrite   = reg_write & reset;
  assign illegal_op = illegal & reset;
  assign state_disp = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit at MEM_WAIT = 0 and 2.
// Control vector: {SrcA,SrcB,ALUCtl,PCen,IorD,MemW,IRW,RegDst,M2R,RegW,PCSrc}.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  localparam logic [13:0] C_FNF  = 14'b0_01_000_01000000;
  localparam logic [13:0] C_FIN  = 14'b0_01_000_11010000;
  localparam logic [13:0] C_DEC  = 14'b0_11_000_00000000;
  localparam logic [13:0] C_MADR = 14'b1_10_000_00000000;
  localparam logic [13:0] C_MRD  = 14'b0_00_000_00000000;
  localparam logic [13:0] C_MWB  = 14'b0_00_000_00000110;
  localparam logic [13:0] C_MWR  = 14'b0_00_000_00100000;
  localparam logic [13:0] C_SUB  = 14'b1_00_001_00000000;
  localparam logic [13:0] C_AWB  = 14'b0_00_000_00001010;
  localparam logic [13:0] C_BRT  = 14'b1_00_001_10000001;
  localparam logic [13:0] C_BRN  = 14'b1_00_001_00000001;
  localparam logic [13:0] C_AEX  = 14'b1_10_000_00000000;
  localparam logic [13:0] C_AWBI = 14'b0_00_000_00000010;

  logic       rst0, z0;
  logic [5:0] op0, fn0;
  logic       a0, pce0, iord0, mw0, irw0, rd0, m2r0, rw0, pcs0, ill0;
  logic [1:0] b0;
  logic [2:0] alu0;
  logic [3:0] st0;
  logic [13:0] c0;
  assign c0 = {a0, b0, alu0, pce0, iord0, mw0, irw0, rd0, m2r0, rw0, pcs0};

  logic       rst2, z2;
  logic [5:0] op2, fn2;
  logic       a2, pce2, iord2, mw2, irw2, rd2, m2r2, rw2, pcs2, ill2;
  logic [1:0] b2;
  logic [2:0] alu2;
  logic [3:0] st2;
  logic [13:0] c2;
  assign c2 = {a2, b2, alu2, pce2, iord2, mw2, irw2, rd2, m2r2, rw2, pcs2};

  multicycle_control_unit #(.MEM_WAIT(0)) u0 (
    .clk(clk), .reset(rst0), .op(op0), .Funct(fn0), .zero(z0),
    .ALUSrcA(a0), .ALUSrcB(b0), .ALUControl(alu0), .PC_enable(pce0),
    .IorD(iord0), .MemWrite(mw0), .IRWrite(irw0), .RegDst(rd0),
    .MemtoReg(m2r0), .RegWrite(rw0), .PCSrc(pcs0),
    .illegal_op(ill0), .state_disp(st0)
  );

  multicycle_control_unit #(.MEM_WAIT(2)) u2 (
    .clk(clk), .reset(rst2), .op(op2), .Funct(fn2), .zero(z2),
    .ALUSrcA(a2), .ALUSrcB(b2), .ALUControl(alu2), .PC_enable(pce2),
    .IorD(iord2), .MemWrite(mw2), .IRWrite(irw2), .RegDst(rd2),
    .MemtoReg(m2r2), .RegWrite(rw2), .PCSrc(pcs2),
    .illegal_op(ill2), .state_disp(st2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (st0 !== 4'd0 || c0 !== C_FNF) begin
        errors++;
        $display("FAIL reset_hold[%0d] st=%0d ctrl=%b exp st=0 ctrl=%b",
                 i, st0, c0, C_FNF);
      end
    end
    rst0 = 1'b1;
    #1;
    checks++;
    if (st0 !== 4'd0 || c0 !== C_FIN) begin
      errors++;
      $display("FAIL reset_release st=%0d ctrl=%b exp st=0 ctrl=%b",
               st0, c0, C_FIN);
    end
  endtask

  task automatic run0(string name, logic [5:0] op, logic [5:0] fn,
                      logic z, int n,
                      logic [3:0] es[6], logic [13:0] ec[6]);
    op0 = op;
    fn0 = fn;
    z0  = z;
    for (int i = 0; i < n; i++) begin
      step();
      checks++;
      if (st0 !== es[i] || c0 !== ec[i]) begin
        errors++;
        $display("FAIL %s[%0d] st=%0d ctrl=%b exp st=%0d ctrl=%b",
                 name, i, st0, c0, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_rtype();
    run0("rtype_sub", 6'h00, 6'h22, 1'b0, 4,
         '{4'd1, 4'd6, 4'd7, 4'd0, 4'd0, 4'd0},
         '{C_DEC, C_SUB, C_AWB, C_FIN, C_FIN, C_FIN});
  endtask

  task automatic test_lw_sw();
    run0("lw", 6'h23, 6'h00, 1'b0, 5,
         '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0},
         '{C_DEC, C_MADR, C_MRD, C_MWB, C_FIN, C_FIN});
    run0("sw", 6'h2B, 6'h00, 1'b0, 4,
         '{4'd1, 4'd2, 4'd5, 4'd0, 4'd0, 4'd0},
         '{C_DEC, C_MADR, C_MWR, C_FIN, C_FIN, C_FIN});
  endtask

  task automatic test_branch();
    run0("beq_taken", 6'h04, 6'h00, 1'b1, 3,
         '{4'd1, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0},
         '{C_DEC, C_BRT, C_FIN, C_FIN, C_FIN, C_FIN});
    run0("beq_not", 6'h04, 6'h00, 1'b0, 3,
         '{4'd1, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0},
         '{C_DEC, C_BRN, C_FIN, C_FIN, C_FIN, C_FIN});
  endtask

  task automatic test_back_to_back();
    run0("addi", 6'h08, 6'h00, 1'b0, 4,
         '{4'd1, 4'd9, 4'd10, 4'd0, 4'd0, 4'd0},
         '{C_DEC, C_AEX, C_AWBI, C_FIN, C_FIN, C_FIN});
    run0("rtype_or", 6'h00, 6'h25, 1'b0, 4,
         '{4'd1, 4'd6, 4'd7, 4'd0, 4'd0, 4'd0},
         '{C_DEC, 14'b1_00_011_00000000, C_AWB, C_FIN, C_FIN, C_FIN});
    run0("rtype_slt", 6'h00, 6'h2A, 1'b0, 4,
         '{4'd1, 4'd6, 4'd7, 4'd0, 4'd0, 4'd0},
         '{C_DEC, 14'b1_00_100_00000000, C_AWB, C_FIN, C_FIN, C_FIN});
  endtask

  task automatic test_illegal();
    logic [5:0] ops[2] = '{6'h3F, 6'h00};
    logic [5:0] fns[2] = '{6'h00, 6'h01};
    for (int k = 0; k < 2; k++) begin
      op0 = ops[k];
      fn0 = fns[k];
      step();
      checks++;
      if (st0 !== 4'd1 || ill0 !== 1'b1) begin
        errors++;
        $display("FAIL illegal_pulse[%0d] st=%0d ill=%b exp st=1 ill=1",
                 k, st0, ill0);
      end
      step();
      checks++;
      if (st0 !== 4'd0 || ill0 !== 1'b0 || c0 !== C_FIN) begin
        errors++;
        $display("FAIL illegal_after[%0d] st=%0d ill=%b ctrl=%b exp 0/0/%b",
                 k, st0, ill0, c0, C_FIN);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [3:0]  es[9] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3,
                           4'd3, 4'd3, 4'd4, 4'd0};
    logic [13:0] ec[9] = '{C_FNF, C_FIN, C_DEC, C_MADR, C_MRD,
                           C_MRD, C_MRD, C_MWB, C_FNF};
    op2 = 6'h23;
    fn2 = 6'h00;
    z2  = 1'b0;
    rst2 = 1'b1;
    #1;
    checks++;
    if (st2 !== 4'd0 || c2 !== C_FNF) begin
      errors++;
      $display("FAIL wait_release st=%0d ctrl=%b exp st=0 ctrl=%b",
               st2, c2, C_FNF);
    end
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (st2 !== es[i] || c2 !== ec[i]) begin
        errors++;
        $display("FAIL wait_lw[%0d] st=%0d ctrl=%b exp st=%0d ctrl=%b",
                 i, st2, c2, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (st2 !== 4'd3) begin
      errors++;
      $display("FAIL abort_reach st=%0d exp 3", st2);
    end
    rst2 = 1'b0;
    #1;
    checks++;
    if (st2 !== 4'd0 || c2 !== C_FNF) begin
      errors++;
      $display("FAIL abort_async st=%0d ctrl=%b exp st=0 ctrl=%b",
               st2, c2, C_FNF);
    end
    step();
    checks++;
    if (st2 !== 4'd0 || rw2 !== 1'b0 || c2 !== C_FNF) begin
      errors++;
      $display("FAIL abort_hold st=%0d rw=%b ctrl=%b exp st=0 rw=0",
               st2, rw2, c2);
    end
    rst2 = 1'b1;
    #1;
    checks++;
    if (st2 !== 4'd0 || c2 !== C_FNF) begin
      errors++;
      $display("FAIL abort_release st=%0d ctrl=%b exp st=0 ctrl=%b",
               st2, c2, C_FNF);
    end
    step();
    step();
    checks++;
    if (st2 !== 4'd0 || irw2 !== 1'b1) begin
      errors++;
      $display("FAIL abort_refetch st=%0d irw=%b exp st=0 irw=1",
               st2, irw2);
    end
  endtask

  initial begin
    rst0 = 1'b0;
    rst2 = 1'b0;
    op0 = 6'h00;
    fn0 = 6'h20;
    z0  = 1'b0;
    op2 = 6'h00;
    fn2 = 6'h20;
    z2  = 1'b0;
    #1;
    test_reset();
    test_rtype();
    test_lw_sw();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_mem_wait();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
